pe_injector: RTL and testbench
==============================

// Module: pe_injector
// PURPOSE
//  Injection controller between a PE client and the pein port of one Hoplite torus switch.
//  Buffers client packets in a small FIFO and presents the head packet to the switch.
//  Holds each packet until the switch accepts it (pein_rdy) and rate-limits injection with a token bucket.
//  The token bucket bounds per-PE network load; one instance per switch, beside the switch in the tile.
// PARAMETERS
//  P_W     32  packet width; the addrx/addry fields are defined in the shared header
//  DEPTH   4   FIFO entries, power of 2, >=2
//  BURST   4   token bucket capacity and reset fill, >=1
//  PERIOD  16  cycles per token refill, >=1 (1 = one token per cycle, effectively unregulated)
//  CNT_W   16  width of the saturating stall counter
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    reset, synchronous, active-high
//  cl_pkt     in   P_W                  client packet
//  cl_vld     in   1                    client packet valid
//  cl_rdy     out  1                    injector can accept; transfer when cl_vld&cl_rdy
//  en         in   1                    injection enable; 0 holds pein_vld low, tokens still accrue
//  pein_pkt   out  P_W                  head packet to switch
//  pein_vld   out  1                    head packet valid to switch
//  pein_rdy   in   1                    switch accepted pein_pkt this cycle (combinational from switch)
//  occ        out  $clog2(DEPTH+1)      FIFO occupancy
//  tokens     out  $clog2(BURST+1)      current token count
//  stall_cnt  out  CNT_W                cycles with pein_vld&!pein_rdy, saturating
// BEHAVIOUR
//  Reset: FIFO empty, occ=0, cl_rdy=1 on the first cycle after reset, pein_vld=0, pein_pkt=0.
//  Reset (cont.): tokens=BURST, refill counter=0, stall_cnt=0. Reset mid-operation discards buffered packets.
//  Push: cl_rdy = (occ!=DEPTH). cl_rdy is decoded from registered state only, never from pein_rdy.
//  Push (cont.): on cl_vld&cl_rdy the packet is written at the tail; occ increments next cycle.
//  pein_vld = en & (occ!=0) & (tokens!=0). It must not depend on pein_rdy (switch loop).
//  pein_pkt = FIFO head; it is stable while pein_vld=1 and not accepted.
//  Pop: on pein_vld&pein_rdy the head is removed next cycle and tokens decrements.
//  No fall-through: a packet pushed in cycle t is offered at earliest in cycle t+1. Empty-push cannot pop same cycle.
//  Simultaneous push+pop: occ unchanged. This is allowed when full only if cl_rdy was already high.
//  cl_rdy is 0 when full, so full+pop frees a slot visible next cycle.
//  Refill: counter counts 0..PERIOD-1 and wraps. On wrap, tokens++ saturating at BURST.
//  Refill+consume in the same cycle: tokens unchanged. Refill at BURST with no consume: stays BURST.
//  Pointers are log2(DEPTH) bits and wrap naturally. occ is tracked separately, so full and empty are distinct.
//  stall_cnt increments when pein_vld&!pein_rdy and holds at all-ones.
//  The switch drops nothing, so the injector never discards a packet except on rst.
// STRUCTURE
//  Shared header: packet field macros (addrx/addry) and width helpers. No local redefinition.
//  Sub-module sync_fifo (P_W, DEPTH): reg-array storage, wr/rd pointers, occ, full/empty.
//  Top level: token bucket, refill counter, valid gating, stall counter.
// TESTING
//  1 Reset, then 4 back-to-back pushes with pein_rdy=1, BURST=4 -> pein_vld from cycle 2.
//    Result: 4 pops in order, tokens 4->0, then pein_vld=0 with occ=0.
//  2 BURST=2, PERIOD=4, 6 packets queued, pein_rdy=1 -> 2 pops back-to-back.
//    Result: then one pop per 4 cycles; tokens never exceed 2.
//  3 Fill to DEPTH=4 with pein_rdy=0 -> cl_rdy=0, pein_pkt constant, stall_cnt counts each cycle.
//    Release pein_rdy -> cl_rdy=1 one cycle after the first pop.
//  4 Push and pop in the same cycle at occ=2 -> occ stays 2; order preserved (tag payloads 0xA0..).
//  5 en=0 for 40 cycles with PERIOD=4, BURST=4 -> no injection, tokens saturate at 4.
//    Set en=1 -> burst of 4 packets.
//  6 Assert rst with occ=3 and tokens=1 -> next cycle occ=0, pein_vld=0, tokens=BURST, stall_cnt=0.
//    Stall counter saturation is forced with CNT_W=4 -> holds at 15.

Source files
------------

// File: rtl/pe_injector_pkg.sv
// Shared definitions for the PE injector: packet address fields, width helpers
// and the token-bucket update encoding.
package pe_injector_pkg;

  localparam int PKT_W_DEF = 32;
  localparam int ADDR_W    = 4;
  localparam int ADDRX_LSB = 0;
  localparam int ADDRY_LSB = ADDRX_LSB + ADDR_W;

  typedef enum logic [1:0] {
    TOK_HOLD = 2'd0,
    TOK_INC  = 2'd1,
    TOK_DEC  = 2'd2
  } tok_op_t;

  // Width able to index 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [ADDR_W-1:0] pkt_addrx(input logic [PKT_W_DEF-1:0] pkt);
    return pkt[ADDRX_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] pkt_addry(input logic [PKT_W_DEF-1:0] pkt);
    return pkt[ADDRY_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO with explicit occupancy so full and empty stay distinct
// while the power-of-two pointers wrap naturally. No fall-through.
module sync_fifo
  import pe_injector_pkg::*;
#(
  parameter int P_W   = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [P_W-1:0]             wr_data,
  input  logic                       rd_en,
  output logic [P_W-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = clog2_min1(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [P_W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // NOTE: storage is deliberately not reset; occ/pointers alone define validity,
  // which keeps the array free of reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pe_injector.sv
// Injection controller for one Hoplite switch port: buffers client packets and
// offers the head to the switch, rate-limited by a token bucket.
module pe_injector
  import pe_injector_pkg::*;
#(
  parameter int P_W    = 32,
  parameter int DEPTH  = 4,
  parameter int BURST  = 4,
  parameter int PERIOD = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [P_W-1:0]             cl_pkt,
  input  logic                       cl_vld,
  output logic                       cl_rdy,
  input  logic                       en,
  output logic [P_W-1:0]             pein_pkt,
  output logic                       pein_vld,
  input  logic                       pein_rdy,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic [$clog2(BURST+1)-1:0] tokens,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int TOK_W = $clog2(BURST + 1);
  localparam int RC_W  = clog2_min1(PERIOD);

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            wrap;
  logic [RC_W-1:0] refill_cnt;
  tok_op_t         tok_op;

  // cl_rdy and pein_vld come only from registered state (plus en), so the
  // switch's combinational pein_rdy cannot close a loop through us.
  assign cl_rdy   = !full;
  assign push     = cl_vld && cl_rdy;
  assign pein_vld = en && !empty && (tokens != '0);
  assign pop      = pein_vld && pein_rdy;
  assign wrap     = (refill_cnt == RC_W'(PERIOD - 1));

  sync_fifo #(
    .P_W   (P_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (cl_pkt),
    .rd_en   (pop),
    .rd_data (pein_pkt),
    .occ     (occ),
    .full    (full),
    .empty   (empty)
  );

  // NOTE: tok_op gets a default before any branch so this block cannot infer a latch.
  always_comb begin
    tok_op = TOK_HOLD;
    if (wrap && !pop && (tokens != TOK_W'(BURST))) tok_op = TOK_INC;
    else if (pop && !wrap)                         tok_op = TOK_DEC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tokens     <= TOK_W'(BURST);
      refill_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      refill_cnt <= wrap ? '0 : refill_cnt + 1'b1;
      case (tok_op)
        TOK_INC: tokens <= tokens + 1'b1;
        TOK_DEC: tokens <= tokens - 1'b1;
        default: tokens <= tokens;
      endcase
      if (pein_vld && !pein_rdy && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_injector.sv
// Self-checking bench for pe_injector: directed phases plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_pe_injector;

  localparam int P_W    = 32;
  localparam int DEPTH  = 4;
  localparam int BURST  = 4;
  localparam int PERIOD = 4;
  localparam int CNT_W  = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [P_W-1:0]             cl_pkt = '0;
  logic                       cl_vld = 1'b0;
  logic                       cl_rdy;
  logic                       en = 1'b0;
  logic [P_W-1:0]             pein_pkt;
  logic                       pein_vld;
  logic                       pein_rdy = 1'b0;
  logic [$clog2(DEPTH+1)-1:0] occ;
  logic [$clog2(BURST+1)-1:0] tokens;
  logic [CNT_W-1:0]           stall_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [P_W-1:0] q[$];
  int  m_tok;
  int  m_cnt;
  int  m_stall;
  bit  model_ok = 1'b0;
  int  pops_seen = 0;

  pe_injector #(
    .P_W    (P_W),
    .DEPTH  (DEPTH),
    .BURST  (BURST),
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cl_pkt    (cl_pkt),
    .cl_vld    (cl_vld),
    .cl_rdy    (cl_rdy),
    .en        (en),
    .pein_pkt  (pein_pkt),
    .pein_vld  (pein_vld),
    .pein_rdy  (pein_rdy),
    .occ       (occ),
    .tokens    (tokens),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [P_W-1:0] obs, input logic [P_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the
  // model with the inputs the DUT samples at the rising edge.
  task automatic cycle();
    bit e_rdy;
    bit e_vld;
    bit do_pop;
    bit do_push;
    @(negedge clk);
    e_rdy = (q.size() != DEPTH);
    e_vld = en && (q.size() != 0) && (m_tok != 0);
    if (model_ok) begin
      check("cl_rdy",    P_W'(cl_rdy),    P_W'(e_rdy));
      check("pein_vld",  P_W'(pein_vld),  P_W'(e_vld));
      check("occ",       P_W'(occ),       P_W'(q.size()));
      check("tokens",    P_W'(tokens),    P_W'(m_tok));
      check("stall_cnt", P_W'(stall_cnt), P_W'(m_stall));
      if (q.size() != 0) check("pein_pkt", pein_pkt, q[0]);
    end
    do_push = cl_vld && e_rdy;
    do_pop  = e_vld && pein_rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_tok    = BURST;
      m_cnt    = 0;
      m_stall  = 0;
      model_ok = 1'b1;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        pops_seen++;
      end
      if (do_push) q.push_back(cl_pkt);
      if (e_vld && !pein_rdy && m_stall < STALL_MAX) m_stall++;
      // Refill and consume net out; bucket never exceeds its capacity.
      m_tok = m_tok - int'(do_pop) + int'(m_cnt == PERIOD - 1);
      if (m_tok > BURST) m_tok = BURST;
      m_cnt = (m_cnt + 1) % PERIOD;
    end
    #1;
  endtask

  task automatic step(input logic v, input logic [P_W-1:0] p, input logic r, input logic e);
    rst      = 1'b0;
    cl_vld   = v;
    cl_pkt   = p;
    pein_rdy = r;
    en       = e;
    cycle();
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    cl_vld = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    int pops0;
    logic [P_W-1:0] held;

    // Reset and first-cycle state
    do_reset(2);
    check("rst_occ",    P_W'(occ),       '0);
    check("rst_vld",    P_W'(pein_vld),  '0);
    check("rst_pkt",    pein_pkt,        '0);
    check("rst_cl_rdy", P_W'(cl_rdy),    P_W'(1));
    check("rst_tokens", P_W'(tokens),    P_W'(BURST));
    check("rst_stall",  P_W'(stall_cnt), '0);

    // Four back-to-back pushes drained with pein_rdy=1; no fall-through
    step(1'b1, 32'h1000_0001, 1'b1, 1'b1);
    check("no_fallthru", P_W'(pein_vld), P_W'(1));
    for (int i = 1; i < 4; i++) step(1'b1, 32'h1000_0001 + P_W'(i), 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("t1_empty", P_W'(occ), '0);

    // Token-limited drain: queue is kept topped up while tokens gate output
    pops0 = pops_seen;
    for (int i = 0; i < 24; i++) step(cl_rdy, $urandom, 1'b1, 1'b1);
    check("t2_rate", P_W'(pops_seen - pops0 <= BURST + 24 / PERIOD), P_W'(1));

    // Fill with pein_rdy=0: head held, stall counter saturates
    for (int i = 0; i < 6; i++) step(1'b1, 32'hB000_0000 + P_W'(i), 1'b0, 1'b1);
    held = pein_pkt;
    check("t3_full_rdy", P_W'(cl_rdy), '0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b1);
    check("t3_held",  pein_pkt, held);
    check("t3_sat",   P_W'(stall_cnt), P_W'(STALL_MAX));
    step(1'b0, '0, 1'b1, 1'b1);
    check("t3_rdy_after_pop", P_W'(cl_rdy), P_W'(1));
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1);

    // Refill tokens with en=0, then simultaneous push+pop at occ=2
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_00A0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_00A1, 1'b0, 1'b1);
    check("t4_occ2", P_W'(occ), P_W'(2));
    step(1'b1, 32'h0000_00A2, 1'b1, 1'b1);
    step(1'b1, 32'h0000_00A3, 1'b1, 1'b1);
    check("t4_occ_kept", P_W'(occ), P_W'(2));
    check("t4_order",    pein_pkt,  32'h0000_00A2);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b1);

    // en=0 for 40 cycles with packets queued, then a full-bucket burst
    for (int i = 0; i < 40; i++) step(i < 4, 32'hC000_0000 + P_W'(i), 1'b1, 1'b0);
    check("t5_tok_sat", P_W'(tokens), P_W'(BURST));
    check("t5_no_inj",  P_W'(occ),    P_W'(4));
    pops0 = pops_seen;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1);
    check("t5_burst", P_W'(pops_seen - pops0), P_W'(4));

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) != 0));

    // Mid-operation reset with packets buffered
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b1);
    check("t6_pre_nonempty", P_W'(occ != 0), P_W'(1));
    do_reset(1);
    check("t6_occ",    P_W'(occ),       '0);
    check("t6_vld",    P_W'(pein_vld),  '0);
    check("t6_tokens", P_W'(tokens),    P_W'(BURST));
    check("t6_stall",  P_W'(stall_cnt), '0);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
